// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction-fetch slice.
//   - opcode field position and the HALT opcode
//   - fetch FSM state encoding
//   - helper that recognises a HALT instruction from its opcode field
package fetch_unit_pkg;

  localparam int OPC_MSB = 19;
  localparam int OPC_LSB = 16;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STOP   = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_e;

  function automatic logic opcode_is_halt(input logic [OPC_MSB-OPC_LSB:0] opc);
    return opc == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_unit_inst_buffer.sv
// inst_buffer: DEPTH-entry circular FIFO holding {inst, pc} pairs.
// Ports:
//   clk, reset  clock, synchronous active-high reset (control state only)
//   push, pop   enqueue din / dequeue head; both may happen in one cycle, even when full
//   flush       empties the buffer; wins over a same-cycle push
//   din, dout   entry in / entry at head (dout is meaningless while empty)
//   count       number of valid entries
//   empty       count == 0
module inst_buffer #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Drives the memory PC port, captures the instruction returned one cycle later
// into a small buffer, and presents {ir, ir_pc} to decode over valid/ready.
// Handles branch redirect (flush + squash of the in-flight read) and HALT.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   pc, fetch_en         fetch address / request qualifier to memory
//   inst                 memory data, valid the cycle after a request
//   ir, ir_pc, ir_valid  buffer head towards decode (zero while not valid)
//   ir_ready             decode accepts the head this cycle
//   redirect, redirect_pc  taken branch/jump and its target
//   halt                 sticky: HALT instruction was consumed by decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 20,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_en,
  input  logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halt
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e state, state_nxt;

  logic [ADDR_W-1:0] req_pc_p1;
  logic              vld_p1;
  logic              squash_p1;

  logic [ENT_W-1:0]  buf_dout;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_empty;
  logic [DATA_W-1:0] head_inst;
  logic [ADDR_W-1:0] head_pc;

  logic              halted;
  logic              redirect_ok;
  logic              pop;
  logic              ret;
  logic              halt_ret;
  logic              halt_pop;
  logic [CNT_W:0]    occ;

  assign halted      = (state == ST_HALTED);
  assign redirect_ok = redirect & ~halted;

  assign head_inst = buf_dout[ENT_W-1:ADDR_W];
  assign head_pc   = buf_dout[ADDR_W-1:0];

  assign ir_valid = ~buf_empty & ~halted;
  assign ir       = ir_valid ? head_inst : '0;
  assign ir_pc    = ir_valid ? head_pc   : '0;
  assign halt     = halted;

  assign pop      = ir_valid & ir_ready;
  assign ret      = vld_p1 & ~squash_p1;
  assign halt_ret = ret & opcode_is_halt(inst[OPC_MSB:OPC_LSB]);
  assign halt_pop = pop & opcode_is_halt(head_inst[OPC_MSB:OPC_LSB]);

  // Occupancy after this edge: the returning read always lands, the head may
  // leave. A new request is only issued if a slot is guaranteed for it.
  // A returning HALT also blocks the request so nothing younger is fetched.
  assign occ      = {1'b0, buf_count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
  assign fetch_en = ~reset & (state == ST_RUN) & ~redirect & ~halt_ret
                    & (occ < (CNT_W+1)'(DEPTH));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (halt_ret && !redirect) state_nxt = ST_STOP;
      ST_STOP: begin
        if (halt_pop)      state_nxt = ST_HALTED;
        else if (redirect) state_nxt = ST_RUN;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // ---- stage 0 -> 1: request issue (pc, FSM, in-flight tracking) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      pc        <= RESET_PC;
      vld_p1    <= 1'b0;
      squash_p1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      vld_p1    <= fetch_en;
      squash_p1 <= redirect_ok & vld_p1;
      if (redirect_ok)   pc <= redirect_pc;
      else if (fetch_en) pc <= pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fetch_en) req_pc_p1 <= pc;
  end

  // ---- stage 1 -> buffer: memory return captured with its address ----
  inst_buffer #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (ret),
    .pop   (pop),
    .flush (redirect_ok),
    .din   ({inst, req_pc_p1}),
    .dout  (buf_dout),
    .count (buf_count),
    .empty (buf_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pc, pc2, ir_pc, ir_pc2, redirect_pc;
  logic        fetch_en, fen2, ir_valid, vld2, halt, halt2;
  logic        ir_ready, redirect;
  logic [19:0] inst, inst2, ir, ir2;
  logic        ready2, redir2;
  logic [9:0]  redir_pc2;
  logic [19:0] mem [1024];

  int n_chk = 0;
  int n_err = 0;

  assign ready2    = 1'b1;
  assign redir2    = 1'b0;
  assign redir_pc2 = '0;

  always #5 clk = ~clk;

  // One-cycle-latency instruction memory shared by both instances.
  always_ff @(posedge clk) begin
    inst  <= mem[pc];
    inst2 <= mem[pc2];
  end

  fetch_unit #(.ADDR_W(10), .DATA_W(20), .DEPTH(2), .RESET_PC(10'h000)) u_dut (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .inst(inst),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );

  fetch_unit #(.ADDR_W(10), .DATA_W(20), .DEPTH(2), .RESET_PC(10'h3FE)) u_wrap (
    .clk(clk), .reset(reset), .pc(pc2), .fetch_en(fen2), .inst(inst2),
    .ir(ir2), .ir_pc(ir_pc2), .ir_valid(vld2), .ir_ready(ready2),
    .redirect(redir2), .redirect_pc(redir_pc2), .halt(halt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset    = 1'b1;
    redirect = 1'b0;
    ir_ready = rdy;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",       32'(pc),       32'h000);
    chk("rst_fetch_en", 32'(fetch_en), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_ir",       32'(ir),       32'd0);
    chk("rst_ir_pc",    32'(ir_pc),    32'd0);
    chk("rst_halt",     32'(halt),     32'd0);
    chk("rst_wrap_pc",  32'(pc2),      32'h3FE);
    chk("rst_wrap_fen", 32'(fen2),     32'd0);
    chk("rst_wrap_halt",32'(halt2),    32'd0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [9:0] e;
    reset       = 1'b1;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    for (int a = 0; a < 1024; a++) mem[a] = 20'h10000 | 20'(a);

    // Streaming with decode always ready; second instance wraps 3FE,3FF,000.
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin tick(); #1; end
      chk("t1_pc",  32'(pc),       32'(i));
      chk("t1_fen", 32'(fetch_en), 32'd1);
      chk("t1_vld", 32'(ir_valid), 32'(i >= 2));
      if (i >= 2) begin
        e = 10'h3FE + 10'(i - 2);
        chk("t1_ir_pc",   32'(ir_pc),  32'(i - 2));
        chk("t1_ir",      32'(ir),     32'(mem[i-2]));
        chk("t1_wrap_vld",32'(vld2),   32'd1);
        chk("t1_wrap_pc", 32'(ir_pc2), 32'(e));
        chk("t1_wrap_ir", 32'(ir2),    32'(mem[e]));
      end
    end

    // Decode stalled: two entries held, fetch stops; release drains in order.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin tick(); #1; end
      if (i == 1) chk("t2_fen_c1", 32'(fetch_en), 32'd1);
      if (i == 2) chk("t2_fen_c2", 32'(fetch_en), 32'd0);
      if (i == 7) begin
        chk("t2_fen_hold",   32'(fetch_en), 32'd0);
        chk("t2_vld_hold",   32'(ir_valid), 32'd1);
        chk("t2_ir_pc_hold", 32'(ir_pc),    32'd0);
        chk("t2_pc_hold",    32'(pc),       32'd2);
      end
    end
    tick();
    ir_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin tick(); #1; end
      chk("t2_drain_vld", 32'(ir_valid), 32'd1);
      chk("t2_drain_pc",  32'(ir_pc),    32'(k));
    end

    // Redirect to 0x200 while the read of 5 is in flight.
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      redirect    = (i == 6);
      redirect_pc = 10'h200;
      #1;
      if (i == 6) begin
        chk("t3_fen_redir", 32'(fetch_en), 32'd0);
        chk("t3_head_4",    32'(ir_pc),    32'd4);
      end
      if (i == 7) begin
        chk("t3_pc_tgt",  32'(pc),       32'h200);
        chk("t3_fen_tgt", 32'(fetch_en), 32'd1);
        chk("t3_vld_c7",  32'(ir_valid), 32'd0);
      end
      if (i == 8) begin
        chk("t3_vld_c8", 32'(ir_valid), 32'd0);
        chk("t3_pc_c8",  32'(pc),       32'h201);
      end
      if (i == 9) begin
        chk("t3_vld_c9",   32'(ir_valid), 32'd1);
        chk("t3_ir_pc_c9", 32'(ir_pc),    32'h200);
        chk("t3_ir_c9",    32'(ir),       32'h10200);
      end
    end
    redirect = 1'b0;

    // HALT at address 3; a later redirect must be ignored.
    mem[3] = 20'hF0000;
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      redirect    = (i == 6);
      redirect_pc = 10'h100;
      #1;
      if (i == 3) begin
        chk("t4_fen_3", 32'(fetch_en), 32'd1);
        chk("t4_pc_3",  32'(pc),       32'd3);
      end
      if (i == 4) begin
        chk("t4_fen_4",   32'(fetch_en), 32'd0);
        chk("t4_pc_4",    32'(pc),       32'd4);
        chk("t4_ir_pc_4", 32'(ir_pc),    32'd2);
      end
      if (i == 5) begin
        chk("t4_vld_5",   32'(ir_valid), 32'd1);
        chk("t4_ir_pc_5", 32'(ir_pc),    32'd3);
        chk("t4_ir_5",    32'(ir),       32'hF0000);
        chk("t4_halt_5",  32'(halt),     32'd0);
        chk("t4_fen_5",   32'(fetch_en), 32'd0);
      end
      if (i == 6) begin
        chk("t4_halt_6", 32'(halt),     32'd1);
        chk("t4_vld_6",  32'(ir_valid), 32'd0);
        chk("t4_fen_6",  32'(fetch_en), 32'd0);
      end
      if (i == 7) begin
        chk("t4_halt_7", 32'(halt),     32'd1);
        chk("t4_pc_7",   32'(pc),       32'd4);
        chk("t4_fen_7",  32'(fetch_en), 32'd0);
        chk("t4_vld_7",  32'(ir_valid), 32'd0);
      end
    end
    redirect = 1'b0;
    mem[3]   = 20'h10003;

    // Reset while an entry is buffered and a read is returning.
    do_reset(1'b0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("t6_fen_in_rst", 32'(fetch_en), 32'd0);
    tick();
    #1;
    chk("t6_vld_after", 32'(ir_valid), 32'd0);
    chk("t6_pc_after",  32'(pc),       32'h000);
    chk("t6_halt_after",32'(halt),     32'd0);
    reset    = 1'b0;
    ir_ready = 1'b1;
    #1;
    chk("t6_vld_c0", 32'(ir_valid), 32'd0);
    tick();
    #1;
    chk("t6_vld_c1", 32'(ir_valid), 32'd0);
    tick();
    #1;
    chk("t6_vld_c2",   32'(ir_valid), 32'd1);
    chk("t6_ir_pc_c2", 32'(ir_pc),    32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
